// File: rtl/axi_lite_rr_arbiter_if.sv
// AXI-lite bundle shared by the arbiter's two requester ports and its downstream port.
// Master drives the request structs (Mw/Mr); Slave drives the response structs (Sw/Sr).
interface AXI_ift #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) ();

  typedef struct packed {
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                bready;
  } mw_t;

  typedef struct packed {
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              rready;
  } mr_t;

  typedef struct packed {
    logic       awready;
    logic       wready;
    logic [1:0] bresp;
    logic       bvalid;
  } sw_t;

  typedef struct packed {
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
  } sr_t;

  mw_t Mw;
  mr_t Mr;
  sw_t Sw;
  sr_t Sr;

  modport Master (output Mw, Mr, input Sw, Sr);
  modport Slave  (input Mw, Mr, output Sw, Sr);

endinterface

// File: rtl/axi_lite_rr_arbiter.sv
// Two-requester AXI-lite arbiter: one whole read or write transaction at a time,
// round-robin between fetch (m0) and data (m1), one-cycle grant latency.
module axi_lite_rr_arbiter #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  AXI_ift.Slave       m0,
  AXI_ift.Slave       m1,
  AXI_ift.Master      out,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_owner;
  logic   r_last;
  logic   w_owner_nxt;
  logic   w_last_nxt;

  logic [1:0] w_req_w;
  logic [1:0] w_req;
  logic       w_winner;

  logic [AXI_ADDR_WIDTH-1:0]   w_awaddr;
  logic [AXI_ADDR_WIDTH-1:0]   w_araddr;
  logic [AXI_DATA_WIDTH-1:0]   w_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] w_wstrb;
  logic                        w_awvalid;
  logic                        w_wvalid;
  logic                        w_bready;
  logic                        w_arvalid;
  logic                        w_rready;

  // Arbitration looks only at request valids, never at downstream responses.
  assign w_req_w  = {m1.Mw.awvalid, m0.Mw.awvalid};
  assign w_req    = w_req_w | {m1.Mr.arvalid, m0.Mr.arvalid};
  assign w_winner = (&w_req) ? ~r_last : w_req[1];

  always_comb begin : owner_mux
    if (r_owner) begin
      w_awaddr  = m1.Mw.awaddr;
      w_awvalid = m1.Mw.awvalid;
      w_wdata   = m1.Mw.wdata;
      w_wstrb   = m1.Mw.wstrb;
      w_wvalid  = m1.Mw.wvalid;
      w_bready  = m1.Mw.bready;
      w_araddr  = m1.Mr.araddr;
      w_arvalid = m1.Mr.arvalid;
      w_rready  = m1.Mr.rready;
    end else begin
      w_awaddr  = m0.Mw.awaddr;
      w_awvalid = m0.Mw.awvalid;
      w_wdata   = m0.Mw.wdata;
      w_wstrb   = m0.Mw.wstrb;
      w_wvalid  = m0.Mw.wvalid;
      w_bready  = m0.Mw.bready;
      w_araddr  = m0.Mr.araddr;
      w_arvalid = m0.Mr.arvalid;
      w_rready  = m0.Mr.rready;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so all three registers update from the same pre-edge values.
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin : next_state
    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_owner_nxt = w_winner;
          w_last_nxt  = w_winner;
          w_state_nxt = w_req_w[w_winner] ? ST_WR : ST_RD;
        end
      end
      ST_RD:   if (out.Sr.rvalid && w_rready) w_state_nxt = ST_IDLE;
      ST_WR:   if (out.Sw.bvalid && w_bready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin : routing
    out.Mw = '0;
    out.Mr = '0;
    m0.Sw  = '0;
    m0.Sr  = '0;
    m1.Sw  = '0;
    m1.Sr  = '0;
    case (r_state)
      ST_RD: begin
        out.Mr.araddr  = w_araddr;
        out.Mr.arvalid = w_arvalid;
        out.Mr.rready  = w_rready;
        if (r_owner) m1.Sr = out.Sr;
        else         m0.Sr = out.Sr;
      end
      ST_WR: begin
        out.Mw.awaddr  = w_awaddr;
        out.Mw.awvalid = w_awvalid;
        out.Mw.wdata   = w_wdata;
        out.Mw.wstrb   = w_wstrb;
        out.Mw.wvalid  = w_wvalid;
        out.Mw.bready  = w_bready;
        if (r_owner) m1.Sw = out.Sw;
        else         m0.Sw = out.Sw;
      end
      default: ;
    endcase
  end

  assign busy  = (r_state != ST_IDLE);
  assign grant = busy ? (r_owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench for axi_lite_rr_arbiter: the bench plays both requesters and the
// downstream slave, driving just after the rising edge and sampling on the falling edge.
module tb_axi_lite_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  AXI_ift #(.ADDR_W(64), .DATA_W(64)) if_m0 ();
  AXI_ift #(.ADDR_W(64), .DATA_W(64)) if_m1 ();
  AXI_ift #(.ADDR_W(64), .DATA_W(64)) if_out ();

  axi_lite_rr_arbiter #(
    .AXI_ADDR_WIDTH(64),
    .AXI_DATA_WIDTH(64)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .m0    (if_m0),
    .m1    (if_m1),
    .out   (if_out),
    .grant (grant),
    .busy  (busy)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [67:0] sr_of(input int m);
    if (m == 0) return if_m0.Sr;
    return if_m1.Sr;
  endfunction

  function automatic logic [4:0] sw_of(input int m);
    if (m == 0) return if_m0.Sw;
    return if_m1.Sw;
  endfunction

  task automatic set_ar(input int m, input logic v, input logic [63:0] a);
    if (m == 0) begin
      if_m0.Mr.arvalid = v;
      if_m0.Mr.araddr  = a;
    end else begin
      if_m1.Mr.arvalid = v;
      if_m1.Mr.araddr  = a;
    end
  endtask

  task automatic set_wr(input int m, input logic v, input logic [63:0] a,
                        input logic [63:0] d, input logic [7:0] s);
    if (m == 0) begin
      if_m0.Mw.awvalid = v; if_m0.Mw.wvalid = v;
      if_m0.Mw.awaddr  = a; if_m0.Mw.wdata  = d; if_m0.Mw.wstrb = s;
    end else begin
      if_m1.Mw.awvalid = v; if_m1.Mw.wvalid = v;
      if_m1.Mw.awaddr  = a; if_m1.Mw.wdata  = d; if_m1.Mw.wstrb = s;
    end
  endtask

  task automatic set_bready(input int m, input logic v);
    if (m == 0) if_m0.Mw.bready = v;
    else        if_m1.Mw.bready = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Entered at a falling edge with master m already granted a read.
  task automatic rd_txn(input int m, input logic [63:0] data, input logic [1:0] resp);
    if_out.Sr.arready = 1'b1;
    #1;
    check("rd_arready", 256'(sr_of(m)), 256'({1'b1, 64'h0, 2'b00, 1'b0}));
    check("rd_other_sr", 256'(sr_of(1 - m)), 256'(0));
    check("rd_mw_zero", 256'(if_out.Mw), 256'(0));
    tick();
    set_ar(m, 1'b0, 64'h0);
    if_out.Sr.arready = 1'b0;
    if_out.Sr.rvalid  = 1'b1;
    if_out.Sr.rdata   = data;
    if_out.Sr.rresp   = resp;
    @(negedge clk);
    check("rd_rbeat", 256'(sr_of(m)), 256'({1'b0, data, resp, 1'b1}));
    check("rd_grant", 256'(grant), 256'((m == 0) ? 2'b01 : 2'b10));
    tick();
    if_out.Sr.rvalid = 1'b0;
    if_out.Sr.rdata  = 64'h0;
    if_out.Sr.rresp  = 2'b00;
    @(negedge clk);
    check("rd_exit", 256'({grant, busy}), 256'(3'b000));
  endtask

  // Entered at a falling edge with master m already granted a write.
  task automatic wr_txn(input int m, input logic [1:0] resp, input int stall);
    if_out.Sw.awready = 1'b1;
    if_out.Sw.wready  = 1'b1;
    #1;
    check("wr_aw_w_ready", 256'(sw_of(m)), 256'({1'b1, 1'b1, 2'b00, 1'b0}));
    check("wr_mr_zero", 256'(if_out.Mr), 256'(0));
    check("wr_other_sw", 256'(sw_of(1 - m)), 256'(0));
    tick();
    set_wr(m, 1'b0, 64'h0, 64'h0, 8'h0);
    set_bready(m, stall == 0);
    if_out.Sw.awready = 1'b0;
    if_out.Sw.wready  = 1'b0;
    if_out.Sw.bvalid  = 1'b1;
    if_out.Sw.bresp   = resp;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("wr_b_stall", 256'({busy, sw_of(m)}), 256'({1'b1, 2'b00, resp, 1'b1}));
      tick();
    end
    set_bready(m, 1'b1);
    @(negedge clk);
    check("wr_bresp", 256'(sw_of(m)), 256'({2'b00, resp, 1'b1}));
    tick();
    if_out.Sw.bvalid = 1'b0;
    if_out.Sw.bresp  = 2'b00;
    @(negedge clk);
    check("wr_exit", 256'({grant, busy}), 256'(3'b000));
  endtask

  initial begin
    int m;
    rst    = 1'b1;
    if_m0.Mw = '0; if_m0.Mr = '0;
    if_m1.Mw = '0; if_m1.Mr = '0;
    if_out.Sw = '0; if_out.Sr = '0;
    if_m0.Mr.rready = 1'b1; if_m1.Mr.rready = 1'b1;
    if_m0.Mw.bready = 1'b1; if_m1.Mw.bready = 1'b1;

    // Reset state and first IDLE cycle
    do_reset();
    @(negedge clk);
    check("rst_grant_busy", 256'({grant, busy}), 256'(3'b000));
    check("rst_out_mw", 256'(if_out.Mw), 256'(0));
    check("rst_out_mr", 256'(if_out.Mr), 256'(0));
    check("rst_m0_s", 256'({if_m0.Sw, if_m0.Sr}), 256'(0));
    check("rst_m1_s", 256'({if_m1.Sw, if_m1.Sr}), 256'(0));

    // Single m0 read with one-cycle grant latency
    set_ar(0, 1'b1, 64'h8000_0000);
    #1;
    check("t1_latency_mr", 256'(if_out.Mr), 256'(0));
    check("t1_latency_grant", 256'(grant), 256'(2'b00));
    tick();
    @(negedge clk);
    check("t1_grant", 256'(grant), 256'(2'b01));
    check("t1_out_mr", 256'(if_out.Mr), 256'({64'h8000_0000, 1'b1, 1'b1}));
    rd_txn(0, 64'hDEAD_BEEF_0000_0001, 2'b00);

    // Simultaneous reads after reset: m0 then m1
    do_reset();
    set_ar(0, 1'b1, 64'h100);
    set_ar(1, 1'b1, 64'h200);
    tick();
    @(negedge clk);
    check("t2_first", 256'(grant), 256'(2'b01));
    rd_txn(0, 64'hA0, 2'b00);
    tick();
    @(negedge clk);
    check("t2_second", 256'(grant), 256'(2'b10));
    check("t2_out_mr", 256'(if_out.Mr), 256'({64'h200, 1'b1, 1'b1}));
    rd_txn(1, 64'hA1, 2'b00);

    // m1 write+read together: write first, read held off
    set_wr(1, 1'b1, 64'h1000, 64'h55, 8'hFF);
    set_ar(1, 1'b1, 64'h1000);
    tick();
    @(negedge clk);
    check("t3_wr_grant", 256'({grant, busy}), 256'(3'b101));
    check("t3_out_mw", 256'(if_out.Mw),
          256'({64'h1000, 1'b1, 64'h55, 8'hFF, 1'b1, 1'b1}));
    check("t3_ar_held", 256'(sr_of(1)), 256'(0));
    wr_txn(1, 2'b00, 0);
    tick();
    @(negedge clk);
    check("t3_rd_grant", 256'(grant), 256'(2'b10));
    check("t3_out_mr", 256'(if_out.Mr), 256'({64'h1000, 1'b1, 1'b1}));
    rd_txn(1, 64'h1234, 2'b00);

    // Continuous contention: grants alternate starting from m0 (m1 served last)
    set_ar(0, 1'b1, 64'h300);
    set_ar(1, 1'b1, 64'h400);
    m = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clk);
      check("t4_alternate", 256'(grant), 256'((m == 0) ? 2'b01 : 2'b10));
      rd_txn(m, 64'(i), 2'b00);
      set_ar(m, 1'b1, (m == 0) ? 64'h300 : 64'h400);
      m = 1 - m;
    end
    set_ar(0, 1'b0, 64'h0);
    set_ar(1, 1'b0, 64'h0);

    // Reset in the middle of an m0 write, after AW but before B
    set_wr(0, 1'b1, 64'h2000, 64'h77, 8'h0F);
    tick();
    @(negedge clk);
    check("t5_wr_grant", 256'(grant), 256'(2'b01));
    if_out.Sw.awready = 1'b1;
    tick();
    if_m0.Mw.awvalid  = 1'b0;
    if_out.Sw.awready = 1'b0;
    @(negedge clk);
    check("t5_in_wr", 256'({grant, busy}), 256'(3'b011));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_m0.Mw.wvalid = 1'b0;
    @(negedge clk);
    check("t5_rst_idle", 256'({grant, busy}), 256'(3'b000));
    check("t5_rst_mw", 256'(if_out.Mw), 256'(0));
    check("t5_rst_m0_sw", 256'(sw_of(0)), 256'(0));
    set_ar(0, 1'b1, 64'h500);
    set_ar(1, 1'b1, 64'h600);
    tick();
    @(negedge clk);
    check("t5_m0_first", 256'(grant), 256'(2'b01));
    rd_txn(0, 64'h50, 2'b00);
    tick();
    @(negedge clk);
    check("t5_m1_second", 256'(grant), 256'(2'b10));
    rd_txn(1, 64'h60, 2'b01);

    // SLVERR with bready held low for 5 cycles
    set_wr(0, 1'b1, 64'h3000, 64'hAA, 8'hFF);
    tick();
    @(negedge clk);
    check("t6_wr_grant", 256'({grant, busy}), 256'(3'b011));
    wr_txn(0, 2'b10, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_rr_arbiter.md
Name: axi_lite_rr_arbiter

Overview:
- Two-master to one-slave AXI-lite arbiter; shares the single MMIO hub master port between the instruction-fetch port (m0) and the data-memory port (m1).
- Grants one complete transaction (read or write) at a time, with round-robin fairness between masters.
- Output port connects directly to the hub's master-facing AXI_ift; non-granted masters see all ready/valid low.

Parameters:
- AXI_ADDR_WIDTH, 64, address width of all three interfaces.
- AXI_DATA_WIDTH, 64, data width of all three interfaces.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- m0  AXI_ift.Slave  bundle  requester 0 (fetch): Mw/Mr in, Sw/Sr out.
- m1  AXI_ift.Slave  bundle  requester 1 (data): Mw/Mr in, Sw/Sr out.
- out  AXI_ift.Master  bundle  to MMIO hub: Mw/Mr out, Sw/Sr in.
- grant  output  2  one-hot current owner {m1,m0}; 0 when idle.
- busy  output  1  high while in RD or WR.

Behaviour:
- States: IDLE, RD, WR; registers: state, owner (1 bit), last (1 bit, last master granted).
- Reset (rst=1 at clk edge): state=IDLE, owner=0, last=1 (m0 wins first). This holds regardless of any transaction in flight; the aborted transaction is dropped, with no response returned.
- In IDLE, and in the first cycle after reset:
  - out.Mw and out.Mr all-zero.
  - m0/m1 Sw and Sr all-zero.
  - grant=0, busy=0.
- Request definition: req_w[i] = mi.Mw.awvalid; req_r[i] = mi.Mr.arvalid; req[i] = req_w[i] | req_r[i].
- Arbitration (IDLE only, combinational on the current cycle, registered at the edge):
  - Only one master requesting: that master wins.
  - Both requesting: the master != last wins.
  - Within the winner: write has priority over read. Next state is WR if req_w[winner], else RD.
  - owner <= winner, last <= winner.
  - No request: stay IDLE.
- Grant latency: 1 cycle. A request first seen in IDLE at cycle N is routed downstream at cycle N+1. Masters hold valid per AXI, so no request is lost.
- RD (owner=k):
  - out.Mr = mk.Mr; mk.Sr = out.Sr.
  - out.Mw = 0; mk.Sw = 0; the other master's Sw/Sr = 0.
  - Exit to IDLE on the edge where out.Sr.rvalid & mk.Mr.rready.
- WR (owner=k):
  - out.Mw = mk.Mw; mk.Sw = out.Sw.
  - out.Mr = 0; mk.Sr = 0; the other master sees 0.
  - AW and W handshakes pass through untouched, in either order or simultaneously.
  - Exit to IDLE on the edge where out.Sw.bvalid & mk.Mw.bready.
- grant = busy ? (owner ? 2'b10 : 2'b01) : 2'b00.
- Write-then-read from the same master: the write completes, one IDLE cycle follows, then re-arbitration. The other master wins if it is requesting.
- A master's request of the other type (e.g. arvalid while its write is granted) is held off, not routed, until re-arbitration.
- Response with no matching ready: stay in state; routing is unchanged and nothing times out.
- Downstream slave errors (bresp/rresp != 0) pass through unchanged; they do not affect state.
- No combinational path from out.S* to the arbitration decision. Only ready/valid feed the exit conditions.

Test Plan:
- Reset, then m0 read of 0x8000_0000 with downstream rdata=0xDEAD_BEEF_0000_0001 → routed at cycle 1 after arvalid; m0 receives rdata/rresp=0; grant=01 during RD; IDLE after the rvalid&rready edge.
- Both masters assert arvalid in the same cycle after reset → m0 served first, m1 second; m1 sees arready=0 until m0's R handshake, then one IDLE cycle, then grant=10.
- m1 asserts awvalid and arvalid together (addr 0x1000, wdata 0x55, wstrb 0xFF) → WR first, B handshake completes, then RD is granted; out.Mr stays 0 throughout WR.
- Back-to-back contention over 8 transactions with both masters continuously requesting → grants alternate 01,10,01,… exactly; neither master is starved.
- rst asserted mid-WR after the AW handshake but before B → next cycle state=IDLE, all outputs 0, grant=00; the next request pair goes to m0 first.
- Downstream returns bresp=2'b10 with bready held low for 5 cycles → arbiter remains in WR for those cycles, passes bresp unchanged, exits on the first bvalid&bready edge.
